float_add_pipe: RTL and testbench

Parametrised, fully pipelined floating-point adder/subtractor with valid/ready handshake. It replaces single-register combinational float adders in the neural datapath (bias add, partial-sum add) wherever backpressure, subtract, correct rounding or non-float32 formats are needed. Operands and result use the packed `{sgn, exp, man}` float layout.

---
 rtl/float_add_pipe.sv | 190 +++++++++++++++++++
 tb/tb_float_add_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_pipe.sv
// float_add_pipe: pipelined float adder/subtractor on packed {sgn, exp, man} operands.
// Stages are S1 align, S2 add, S3 normalise/round and a result-select output register, all gated by one advance enable.
module float_add_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int FTZ_EXP = 10,
    parameter int TAG_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_sum,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = 2 * MAN_W + 3;
    localparam int ER_W = EXP_W + 2;
    localparam int P_W  = $clog2(F + 1);
    localparam logic signed [ER_W-1:0] FTZ_LIM = ER_W'(FTZ_EXP);
    localparam logic signed [ER_W-1:0] OVF_LIM = ER_W'((1 << EXP_W) - 1);
    localparam logic        [ER_W-1:0] HID_POS = ER_W'(2 * MAN_W);

    function automatic logic signed [F-1:0] ext_op(input logic sgn, input logic [MAN_W-1:0] man,
                                                   input logic flush);
        logic signed [MAN_W+2:0] m;
        m = flush ? '0 : $signed({2'b00, 1'b1, man});
        m = sgn ? -m : m;
        return {m, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [P_W-1:0] lead_one(input logic [F:0] v);
        logic [P_W-1:0] idx;
        idx = '0;
        for (int i = 0; i <= F; i++) begin
            idx = v[i] ? P_W'(i) : idx;
        end
        return idx;
    endfunction

    logic                      adv_s;
    logic [EXP_W-1:0]          ea_s, eb_s, e_max_s;
    logic                      a_flush_s, b_flush_s, a_ge_s;
    logic [EXP_W:0]            del_s, shamt_s;
    logic signed [F-1:0]       a_ext_s, b_ext_s, a_al_s, b_al_s;

    logic                      s1_valid_r, s1_bflush_r;
    logic signed [F-1:0]       s1_a_r, s1_b_r;
    logic [EXP_W-1:0]          s1_emax_r;
    logic [TAG_W-1:0]          s1_tag_r;

    logic [F:0]                sum_s, mag_s;

    logic                      s2_valid_r, s2_bflush_r, s2_sign_r;
    logic [F:0]                s2_mag_r;
    logic [EXP_W-1:0]          s2_emax_r;
    logic [TAG_W-1:0]          s2_tag_r;

    logic [P_W-1:0]            p_s;
    logic [F:0]                norm_s;
    logic                      guard_s, sticky_s, inc_s;
    logic [MAN_W:0]            man_inc_s;
    logic signed [ER_W-1:0]    er_s;

    logic                      s3_valid_r, s3_bflush_r, s3_sign_r, s3_zero_r;
    logic signed [ER_W-1:0]    s3_er_r;
    logic [MAN_W-1:0]          s3_man_r;
    logic [TAG_W-1:0]          s3_tag_r;

    logic [W-1:0]              res_s;
    logic [2:0]                flags_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;
    assign ea_s     = in_a[W-2 -: EXP_W];
    assign eb_s     = in_b[W-2 -: EXP_W];

    // S1: flush small exponents, sign the mantissas and align the smaller operand.
    always_comb begin
        a_flush_s = int'(ea_s) < FTZ_EXP;
        b_flush_s = int'(eb_s) < FTZ_EXP;
        del_s     = {1'b0, ea_s} - {1'b0, eb_s};
        a_ge_s    = ~del_s[EXP_W];
        shamt_s   = a_ge_s ? del_s : ({(EXP_W+1){1'b0}} - del_s);
        e_max_s   = a_ge_s ? ea_s : eb_s;
        a_ext_s   = ext_op(in_a[W-1], in_a[MAN_W-1:0], a_flush_s);
        b_ext_s   = ext_op(in_b[W-1] ^ in_sub, in_b[MAN_W-1:0], b_flush_s);
        a_al_s    = a_ge_s ? a_ext_s : (a_ext_s >>> shamt_s);
        b_al_s    = a_ge_s ? (b_ext_s >>> shamt_s) : b_ext_s;
    end

    // S2: sign-extended add, then split into sign and magnitude.
    always_comb begin
        sum_s = {s1_a_r[F-1], s1_a_r} + {s1_b_r[F-1], s1_b_r};
        mag_s = sum_s[F] ? -sum_s : sum_s;
    end

    // S3: left-justify the leading one at bit F, then round to nearest even on guard/sticky.
    always_comb begin
        p_s       = lead_one(s2_mag_r);
        norm_s    = s2_mag_r << (P_W'(F) - p_s);
        guard_s   = norm_s[F-1-MAN_W];
        sticky_s  = |norm_s[F-2-MAN_W:0];
        inc_s     = guard_s & (sticky_s | norm_s[F-MAN_W]);
        man_inc_s = {1'b0, norm_s[F-1 -: MAN_W]} + {{MAN_W{1'b0}}, inc_s};
        er_s      = $signed(ER_W'(s2_emax_r) + ER_W'(p_s) - HID_POS + ER_W'(man_inc_s[MAN_W]));
    end

    // Result select; both-flushed is tested before the zero-magnitude case so it reports ftz.
    always_comb begin
        if (s3_bflush_r) begin
            res_s   = '0;
            flags_s = 3'b011;
        end else if (s3_zero_r) begin
            res_s   = '0;
            flags_s = 3'b001;
        end else if (s3_er_r < FTZ_LIM) begin
            res_s   = '0;
            flags_s = 3'b011;
        end else if (s3_er_r >= OVF_LIM) begin
            res_s   = {s3_sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags_s = 3'b100;
        end else begin
            res_s   = {s3_sign_r, s3_er_r[EXP_W-1:0], s3_man_r};
            flags_s = 3'b000;
        end
    end

    // Pipeline registers: all stages, bubbles included, move together on adv and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r  <= 1'b0;
            s1_bflush_r <= 1'b0;
            s1_a_r      <= '0;
            s1_b_r      <= '0;
            s1_emax_r   <= '0;
            s1_tag_r    <= '0;
            s2_valid_r  <= 1'b0;
            s2_bflush_r <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_mag_r    <= '0;
            s2_emax_r   <= '0;
            s2_tag_r    <= '0;
            s3_valid_r  <= 1'b0;
            s3_bflush_r <= 1'b0;
            s3_sign_r   <= 1'b0;
            s3_zero_r   <= 1'b0;
            s3_er_r     <= '0;
            s3_man_r    <= '0;
            s3_tag_r    <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_tag     <= '0;
            out_flags   <= 3'b000;
        end else if (adv_s) begin
            s1_valid_r  <= in_valid;
            s1_bflush_r <= a_flush_s & b_flush_s;
            s1_a_r      <= a_al_s;
            s1_b_r      <= b_al_s;
            s1_emax_r   <= e_max_s;
            s1_tag_r    <= in_tag;
            s2_valid_r  <= s1_valid_r;
            s2_bflush_r <= s1_bflush_r;
            s2_sign_r   <= sum_s[F];
            s2_mag_r    <= mag_s;
            s2_emax_r   <= s1_emax_r;
            s2_tag_r    <= s1_tag_r;
            s3_valid_r  <= s2_valid_r;
            s3_bflush_r <= s2_bflush_r;
            s3_sign_r   <= s2_sign_r;
            s3_zero_r   <= ~norm_s[F];
            s3_er_r     <= er_s;
            s3_man_r    <= man_inc_s[MAN_W-1:0];
            s3_tag_r    <= s2_tag_r;
            out_valid   <= s3_valid_r;
            if (s3_valid_r) begin
                out_sum   <= res_s;
                out_tag   <= s3_tag_r;
                out_flags <= flags_s;
            end
        end
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// Self-checking bench for float_add_pipe (float32 defaults): directed spec vectors,
// backpressure, randomized traffic against an exact-integer reference, and reset mid-stream.
module tb_float_add_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;

    float_add_pipe #(.EXP_W(8), .MAN_W(23), .FTZ_EXP(10), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag), .out_flags(out_flags)
    );

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  tag;
        logic [2:0]  fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic        s_acc, s_got, s_ov, s_ir;
    logic [31:0] s_sum;
    logic [3:0]  s_tag;
    logic [2:0]  s_fl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact integer value of each operand scaled by 2^46, floor-aligned, added, then RNE by remainder.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                    output logic [31:0] r, output logic [2:0] fl);
        int     ea, eb, emax, d, p, er, sh;
        logic   fa, fb, sgn;
        longint va, vb, sum, mag, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = ea < 10;
        fb = eb < 10;
        va = 0;
        vb = 0;
        if (!fa) va = longint'({1'b1, a[22:0]}) << 23;
        if (!fb) vb = longint'({1'b1, b[22:0]}) << 23;
        if (a[31]) va = -va;
        if (b[31] ^ sub) vb = -vb;
        emax = (ea > eb) ? ea : eb;
        d    = (ea > eb) ? ea - eb : eb - ea;
        if (ea < eb) va = (d >= 63) ? ((va < 0) ? -1 : 0) : (va >>> d);
        else if (eb < ea) vb = (d >= 63) ? ((vb < 0) ? -1 : 0) : (vb >>> d);
        sum = va + vb;
        sgn = sum < 0;
        mag = sgn ? -sum : sum;
        if (fa && fb) begin
            r = 32'h0; fl = 3'b011; return;
        end
        if (mag == 0) begin
            r = 32'h0; fl = 3'b001; return;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        er = emax + p - 46;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = mag << (23 - p);
        end
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            er++;
        end
        if (er < 10) begin
            r = 32'h0; fl = 3'b011;
        end else if (er >= 255) begin
            r = {sgn, 8'hFE, 23'h7FFFFF}; fl = 3'b100;
        end else begin
            r = {sgn, 8'(er), 23'(q - (longint'(1) << 23))}; fl = 3'b000;
        end
    endfunction

    task automatic push_ref(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        exp_t        e;
        logic [31:0] r;
        logic [2:0]  f;
        ref_add(a, b, s, r, f);
        e.sum = r; e.tag = t; e.fl = f;
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs at negedge and sample DUT state shortly after.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] t, input logic ordy);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_sub = s; in_tag = t; out_ready = ordy;
        #1;
        s_acc = v && in_ready;
        s_got = out_valid && out_ready;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_sum = out_sum;
        s_tag = out_tag;
        s_fl  = out_flags;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_sub = 1'b0;
        in_tag = 4'h0; out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h want 0", out_sum); end
        n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        n_cmp++; if (out_flags !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", out_flags); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [0:12];
        logic [31:0] tb [0:12];
        logic        ts [0:12];
        logic [31:0] tr [0:12];
        logic [2:0]  tf [0:12];
        int          idx;
        exp_t        e;
        ta = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
               32'h04800000, 32'h05000000, 32'h7F800000, 32'h05800000, 32'h05000000, 32'hFF7FFFFF};
        tb = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h33800000, 32'h33C00000, 32'h33800000, 32'h7F7FFFFF,
               32'h00000000, 32'h85000000, 32'h00000000, 32'h05400000, 32'h00000000, 32'hFF7FFFFF};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tr = '{32'h40400000, 32'h00000000, 32'hBF800000, 32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h7F7FFFFF,
               32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'h00000000, 32'h05000000, 32'hFF7FFFFF};
        tf = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
               3'b011, 3'b001, 3'b100, 3'b011, 3'b000, 3'b100};
        exp_q.delete();
        idx = 0;
        for (int k = 0; k < 100 && (idx < 13 || exp_q.size() != 0); k++) begin
            if (idx < 13) cycle(1'b1, ta[idx], tb[idx], ts[idx], 4'(idx + 5), 1'b1);
            else cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
            if (s_acc) begin
                e.sum = tr[idx]; e.tag = 4'(idx + 5); e.fl = tf[idx];
                exp_q.push_back(e);
                idx++;
            end
            if (s_got) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL dir_extra: got sum=%h tag=%h, want no result", s_sum, s_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_sum, s_tag, s_fl} !== {e.sum, e.tag, e.fl}) begin
                        n_err++;
                        $display("FAIL dir_result: got sum=%h tag=%h flags=%b, want sum=%h tag=%h flags=%b",
                                 s_sum, s_tag, s_fl, e.sum, e.tag, e.fl);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || idx != 13) begin
            n_err++; $display("FAIL dir_drain: got %0d pending %0d sent, want 0 pending 13 sent", exp_q.size(), idx);
        end
    endtask

    task automatic test_backpressure();
        int          sent;
        logic        ordy, prev_stall;
        logic [39:0] prev_out;
        logic [31:0] a, b;
        exp_t        e;
        exp_q.delete();
        sent = 0; prev_stall = 1'b0; prev_out = '0;
        for (int k = 0; k < 60 && (sent < 8 || exp_q.size() != 0); k++) begin
            ordy = !(k >= 4 && k <= 8);
            a = {1'b0, 8'(100 + sent), 23'($urandom)};
            b = {1'($urandom), 8'(98 + sent), 23'($urandom)};
            cycle(sent < 8, a, b, 1'b0, 4'(sent), ordy);
            if (k >= 4 && k <= 8) begin
                n_cmp++;
                if (s_ir !== 1'b0 || s_ov !== 1'b1) begin
                    n_err++; $display("FAIL bp_stall k=%0d: got in_ready=%b out_valid=%b, want 0 1", k, s_ir, s_ov);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if ({s_ov, s_sum, s_tag, s_fl} !== prev_out) begin
                    n_err++; $display("FAIL bp_hold k=%0d: got %h want %h", k, {s_ov, s_sum, s_tag, s_fl}, prev_out);
                end
            end
            prev_stall = s_ov && !ordy;
            prev_out   = {s_ov, s_sum, s_tag, s_fl};
            if (s_acc) begin
                push_ref(a, b, 1'b0, 4'(sent));
                sent++;
            end
            if (s_got) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra: got tag=%h, want no result", s_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_sum, s_tag, s_fl} !== {e.sum, e.tag, e.fl}) begin
                        n_err++;
                        $display("FAIL bp_result: got sum=%h tag=%h flags=%b, want sum=%h tag=%h flags=%b",
                                 s_sum, s_tag, s_fl, e.sum, e.tag, e.fl);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || sent != 8) begin
            n_err++; $display("FAIL bp_drain: got %0d pending %0d sent, want 0 pending 8 sent", exp_q.size(), sent);
        end
    endtask

    task automatic test_random();
        int          sent, ea, eb, m;
        logic        v, s, ordy, prev_stall;
        logic [39:0] prev_out;
        logic [31:0] a, b;
        exp_t        e;
        exp_q.delete();
        sent = 0; prev_stall = 1'b0; prev_out = '0;
        for (int k = 0; k < 4000 && (sent < 400 || exp_q.size() != 0); k++) begin
            m  = int'($urandom_range(0, 9));
            ea = (m == 0) ? int'($urandom_range(0, 12)) :
                 (m == 1) ? int'($urandom_range(240, 255)) : int'($urandom_range(13, 239));
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            a = {1'($urandom), 8'(ea), 23'($urandom)};
            b = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
            s    = 1'($urandom);
            v    = ($urandom_range(0, 9) < 8) && (sent < 400);
            ordy = $urandom_range(0, 9) < 7;
            cycle(v, a, b, s, 4'(sent), ordy);
            if (prev_stall) begin
                n_cmp++;
                if ({s_ov, s_sum, s_tag, s_fl} !== prev_out) begin
                    n_err++; $display("FAIL rand_hold k=%0d: got %h want %h", k, {s_ov, s_sum, s_tag, s_fl}, prev_out);
                end
            end
            prev_stall = s_ov && !ordy;
            prev_out   = {s_ov, s_sum, s_tag, s_fl};
            if (s_acc) begin
                push_ref(a, b, s, 4'(sent));
                sent++;
            end
            if (s_got) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got tag=%h, want no result", s_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_sum, s_tag, s_fl} !== {e.sum, e.tag, e.fl}) begin
                        n_err++;
                        $display("FAIL rand_result: got sum=%h tag=%h flags=%b, want sum=%h tag=%h flags=%b",
                                 s_sum, s_tag, s_fl, e.sum, e.tag, e.fl);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || sent != 400) begin
            n_err++; $display("FAIL rand_drain: got %0d pending %0d sent, want 0 pending 400 sent", exp_q.size(), sent);
        end
    endtask

    task automatic test_reset_midstream();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h3F800000, 32'h40000000 + (32'(k) << 23), 1'b0, 4'(9 + k), 1'b1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b1) begin n_err++; $display("FAIL rst_inflight: got out_valid=%b want 1", s_ov); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_sum, out_tag, out_flags} !== {1'b0, 32'h0, 4'h0, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid: got valid=%b sum=%h tag=%h flags=%b, want all 0", out_valid, out_sum, out_tag, out_flags);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
            n_cmp++;
            if (s_ov !== 1'b0) begin n_err++; $display("FAIL rst_stale k=%0d: got out_valid=1 tag=%h want 0", k, s_tag); end
        end
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'hC, 1'b1);
        n_cmp++;
        if (s_acc !== 1'b1) begin n_err++; $display("FAIL rst_accept: got %b want 1", s_acc); end
        for (int j = 1; j <= 5; j++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
            n_cmp++;
            if (s_ov !== (j == 4)) begin
                n_err++; $display("FAIL rst_latency j=%0d: got out_valid=%b want %b", j, s_ov, (j == 4));
            end
            if (j == 4) begin
                n_cmp++;
                if ({s_sum, s_tag, s_fl} !== {32'h40400000, 4'hC, 3'b000}) begin
                    n_err++; $display("FAIL rst_result: got sum=%h tag=%h flags=%b, want 40400000 c 000", s_sum, s_tag, s_fl);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
